// File: rtl/gg_dma_pkg.sv
// Shared types and AXI constants for the macroblock read-DMA address path.
package gg_dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ISSUE,
        DRAIN
    } rdaddr_state_t;

    localparam int unsigned MB_BEATS        = 24;
    localparam logic [7:0]  AXI_ARLEN_MB    = 8'd23;
    localparam logic [2:0]  AXI_ARSIZE_128  = 3'b100;
    localparam logic [3:0]  AXI_ARCACHE_DMA = 4'b0011;

endpackage

// File: rtl/gg_dma_outstanding.sv
// Outstanding-burst counter: AR handshakes count up, R-last beats count down.
// Flags full at MAX_OUT and holds a sticky error on R-last with nothing outstanding.
module gg_dma_outstanding #(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_err,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty,
    output logic err
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            // Simultaneous inc and dec cancel; a dec at zero never wraps.
            if (inc && !dec) begin
                count <= count + 1'b1;
            end else if (dec && !inc && count != '0) begin
                count <= count - 1'b1;
            end

            if (dec && count == '0) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

    assign full  = (count == CNT_W'(MAX_OUT));
    assign empty = (count == '0);

endmodule

// File: rtl/gg_dma_rdaddr.sv
// AXI4 read-address generator: one 24-beat 128-bit burst per macroblock from a
// circular buffer. Define GG_DMA_RDADDR_PERF_EN to add stall performance counters.
module gg_dma_rdaddr
    import gg_dma_pkg::*;
#(
    parameter int unsigned ADDR_W    = 40,
    parameter int unsigned MB_STRIDE = 512,
    parameter int unsigned MAX_OUT   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic              cont,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] limit_addr,
    input  logic [ADDR_W-1:0] write_addr,
    output logic [ADDR_W-1:0] read_addr,
    output logic              busy,
    output logic              waiting,
    output logic [15:0]       mb_count,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [3:0]        m_arcache,
    input  logic              m_rvalid,
    input  logic              m_rready,
    input  logic              m_rlast,
`ifdef GG_DMA_RDADDR_PERF_EN
    output logic [31:0]       stall_wr_cycles,
    output logic [31:0]       stall_ar_cycles,
`endif
    output logic              err
);

    rdaddr_state_t state, state_next;

    logic [ADDR_W:0] next_sum;
    logic            wrap;
    logic            ptr_eq;
    logic            start;
    logic            load_ar;
    logic            ar_hs;
    logic            r_last;
    logic            out_full;
    logic            out_empty;
    logic            blocked_full;

    // One extra bit keeps the wrap compare valid at the top of the address space.
    assign next_sum = {1'b0, read_addr} + (ADDR_W + 1)'(MB_STRIDE);
    assign wrap     = (next_sum >= {1'b0, limit_addr});
    assign ptr_eq   = (read_addr == write_addr);
    assign start    = (state == IDLE) && go;
    assign ar_hs    = (state == ISSUE) && m_arready;
    assign r_last   = m_rvalid && m_rready && m_rlast;

    always_comb begin
        state_next   = state;
        waiting      = 1'b0;
        load_ar      = 1'b0;
        blocked_full = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) state_next = CHECK;
            end
            CHECK: begin
                if (!go) begin
                    state_next = DRAIN;
                end else if (!cont && ptr_eq) begin
                    waiting = 1'b1;
                end else if (out_full) begin
                    blocked_full = 1'b1;
                end else begin
                    load_ar    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (m_arready) state_next = CHECK;
            end
            DRAIN: begin
                if (out_empty) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            read_addr <= '0;
            m_araddr  <= '0;
            mb_count  <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                read_addr <= base_addr;
                mb_count  <= '0;
            end
            if (load_ar) begin
                m_araddr <= read_addr;
            end
            if (ar_hs) begin
                read_addr <= wrap ? base_addr : next_sum[ADDR_W-1:0];
                mb_count  <= mb_count + 16'd1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign m_arvalid = (state == ISSUE);
    assign m_arlen   = AXI_ARLEN_MB;
    assign m_arsize  = AXI_ARSIZE_128;
    assign m_arcache = AXI_ARCACHE_DMA;

    gg_dma_outstanding #(
        .MAX_OUT(MAX_OUT)
    ) u_outstanding (
        .clk    (clk),
        .reset_n(reset_n),
        .clr_err(start),
        .inc    (ar_hs),
        .dec    (r_last),
        .full   (out_full),
        .empty  (out_empty),
        .err    (err)
    );

`ifdef GG_DMA_RDADDR_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_wr_cycles <= '0;
            stall_ar_cycles <= '0;
        end else if (start) begin
            stall_wr_cycles <= '0;
            stall_ar_cycles <= '0;
        end else begin
            if (waiting && stall_wr_cycles != '1) begin
                stall_wr_cycles <= stall_wr_cycles + 32'd1;
            end
            if (((state == ISSUE && !m_arready) || blocked_full) && stall_ar_cycles != '1) begin
                stall_ar_cycles <= stall_ar_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gg_dma_rdaddr.sv
// Self-checking bench for gg_dma_rdaddr: vector table of buffer setups plus
// hand sequences for outstanding limit, go drop, async reset and error flag.
module tb_gg_dma_rdaddr;

    localparam int unsigned AW = 40;
    localparam logic [14:0] ATTR_EXP = {8'd23, 3'b100, 4'b0011};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          go = 1'b0;
    logic          cont = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] limit_addr = '0;
    logic [AW-1:0] write_addr = '0;
    logic [AW-1:0] read_addr;
    logic          busy;
    logic          waiting;
    logic [15:0]   mb_count;
    logic          m_arvalid;
    logic          m_arready = 1'b0;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [3:0]    m_arcache;
    logic          m_rvalid = 1'b0;
    logic          m_rready = 1'b0;
    logic          m_rlast = 1'b0;
    logic          err;

    always #5 clk = ~clk;

    gg_dma_rdaddr #(
        .ADDR_W   (AW),
        .MB_STRIDE(512),
        .MAX_OUT  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .go        (go),
        .cont      (cont),
        .base_addr (base_addr),
        .limit_addr(limit_addr),
        .write_addr(write_addr),
        .read_addr (read_addr),
        .busy      (busy),
        .waiting   (waiting),
        .mb_count  (mb_count),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arcache (m_arcache),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rlast   (m_rlast),
        .err       (err)
    );

    int n_checks = 0;
    int n_fail = 0;

    // AR monitor: records every handshake seen before the edge that completes it.
    logic [AW-1:0] obs_addr [0:255];
    logic [14:0]   obs_attr [0:255];
    int            obs_n = 0;

    always @(negedge clk) begin
        if (reset_n && m_arvalid && m_arready && obs_n < 256) begin
            obs_addr[obs_n] = m_araddr;
            obs_attr[obs_n] = {m_arlen, m_arsize, m_arcache};
            obs_n++;
        end
    end

    // R responder: one R-last per recorded AR when enabled, plus injected extras.
    logic rsp_en = 1'b0;
    int   r_sent = 0;
    int   flushed = 0;
    int   inj_req = 0;
    int   inj_done = 0;

    always @(posedge clk) begin
        #3;
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rlast  = 1'b0;
        if (inj_req != inj_done) begin
            inj_done++;
            {m_rvalid, m_rready, m_rlast} = 3'b111;
        end else if (rsp_en && (obs_n - r_sent - flushed) > 0) begin
            r_sent++;
            {m_rvalid, m_rready, m_rlast} = 3'b111;
        end
    end

    logic [AW-1:0] exp_q [$];
    int            rd_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic compare_obs(input string tag);
        logic [AW-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < obs_n) begin
                check({tag, " araddr"}, 64'(obs_addr[rd_idx]), 64'(e));
                check({tag, " arlen/size/cache"}, 64'(obs_attr[rd_idx]), 64'(ATTR_EXP));
                rd_idx++;
            end else begin
                check({tag, " missing AR"}, 64'(obs_n), 64'(rd_idx + 1));
            end
        end
        check({tag, " AR count"}, 64'(obs_n), 64'(rd_idx));
        rd_idx = obs_n;
    endtask

    task automatic do_reset();
        go = 1'b0;
        rsp_en = 1'b0;
        m_arready = 1'b0;
        reset_n = 1'b0;
        step(2);
        flushed = obs_n - r_sent;
        rd_idx = obs_n;
        exp_q.delete();
        reset_n = 1'b1;
        step(1);
    endtask

    typedef struct {
        logic          cont;
        logic [AW-1:0] base;
        logic [AW-1:0] limit;
        logic [AW-1:0] wr;
        int            stop_after;
        int            n_exp;
        logic [15:0]   exp_mb;
        logic [AW-1:0] exp_rd;
        logic          exp_wait;
    } vec_t;

    vec_t          vecs [5];
    logic [AW-1:0] row_addr [5][7];

    initial begin
        int t;

        vecs[0] = '{1'b0, 40'h1000, 40'h1800, 40'h1400, 0, 2, 16'd2, 40'h1400, 1'b1};
        vecs[1] = '{1'b1, 40'h1000, 40'h1600, 40'h0, 7, 7, 16'd7, 40'h1200, 1'b0};
        vecs[2] = '{1'b0, 40'h2000, 40'h2800, 40'h2000, 0, 0, 16'd0, 40'h2000, 1'b1};
        vecs[3] = '{1'b1, 40'h3000, 40'h3000, 40'h0, 3, 3, 16'd3, 40'h3000, 1'b0};
        vecs[4] = '{1'b1, 40'hFF_FFFF_FC00, 40'hFF_FFFF_FFFF, 40'h0, 3, 3, 16'd3, 40'hFF_FFFF_FE00, 1'b0};
        row_addr[0] = '{40'h1000, 40'h1200, '0, '0, '0, '0, '0};
        row_addr[1] = '{40'h1000, 40'h1200, 40'h1400, 40'h1000, 40'h1200, 40'h1400, 40'h1000};
        row_addr[2] = '{'0, '0, '0, '0, '0, '0, '0};
        row_addr[3] = '{40'h3000, 40'h3000, 40'h3000, '0, '0, '0, '0};
        row_addr[4] = '{40'hFF_FFFF_FC00, 40'hFF_FFFF_FE00, 40'hFF_FFFF_FC00, '0, '0, '0, '0};

        // Reset state, observed while reset is still asserted.
        step(2);
        check("rst read_addr", 64'(read_addr), 64'h0);
        check("rst m_araddr", 64'(m_araddr), 64'h0);
        check("rst mb_count", 64'(mb_count), 64'h0);
        check("rst m_arvalid", 64'(m_arvalid), 64'h0);
        check("rst busy", 64'(busy), 64'h0);
        check("rst waiting", 64'(waiting), 64'h0);
        check("rst err", 64'(err), 64'h0);
        check("const arlen", 64'(m_arlen), 64'd23);
        reset_n = 1'b1;
        step(1);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            cont = vecs[v].cont;
            base_addr = vecs[v].base;
            limit_addr = vecs[v].limit;
            write_addr = vecs[v].wr;
            m_arready = 1'b1;
            rsp_en = 1'b1;
            for (int i = 0; i < vecs[v].n_exp; i++) exp_q.push_back(row_addr[v][i]);
            t = obs_n;
            go = 1'b1;
            if (vecs[v].stop_after > 0) begin
                for (int c = 0; c < 200 && go; c++) begin
                    step(1);
                    if (obs_n - t >= vecs[v].stop_after) go = 1'b0;
                end
                check($sformatf("vec%0d go-drop timeout", v), 64'(go), 64'h0);
                t = 0;
                while (busy && t < 100) begin
                    step(1);
                    t++;
                end
                check($sformatf("vec%0d drain timeout", v), 64'(busy), 64'h0);
            end else begin
                t = 0;
                while (!waiting && t < 100) begin
                    step(1);
                    t++;
                end
                step(6);
            end
            compare_obs($sformatf("vec%0d", v));
            check($sformatf("vec%0d waiting", v), 64'(waiting), 64'(vecs[v].exp_wait));
            check($sformatf("vec%0d mb_count", v), 64'(mb_count), 64'(vecs[v].exp_mb));
            check($sformatf("vec%0d read_addr", v), 64'(read_addr), 64'(vecs[v].exp_rd));
        end

        // Original mode: advancing the write pointer releases exactly one burst.
        do_reset();
        cont = 1'b0;
        base_addr = 40'h1000;
        limit_addr = 40'h1800;
        write_addr = 40'h1400;
        m_arready = 1'b1;
        rsp_en = 1'b1;
        exp_q.push_back(40'h1000);
        exp_q.push_back(40'h1200);
        go = 1'b1;
        t = 0;
        while (!waiting && t < 100) begin
            step(1);
            t++;
        end
        check("orig first waiting", 64'(waiting), 64'h1);
        compare_obs("orig first");
        write_addr = 40'h1600;
        exp_q.push_back(40'h1400);
        step(10);
        compare_obs("orig advance");
        check("orig advance waiting", 64'(waiting), 64'h1);
        check("orig advance read_addr", 64'(read_addr), 64'h1600);
        check("orig advance mb_count", 64'(mb_count), 64'd3);

        // Outstanding limit, single release, and coincident AR + R-last.
        do_reset();
        cont = 1'b1;
        base_addr = 40'h1000;
        limit_addr = 40'h2000;
        write_addr = 40'h0;
        m_arready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(40'h1000 + 40'(i * 512));
        go = 1'b1;
        step(20);
        compare_obs("maxout");
        check("maxout busy", 64'(busy), 64'h1);
        check("maxout arvalid", 64'(m_arvalid), 64'h0);
        exp_q.push_back(40'h1800);
        inj_req++;
        step(10);
        compare_obs("one rlast");
        m_arready = 1'b0;
        exp_q.push_back(40'h1A00);
        inj_req++;
        t = 0;
        while (!m_arvalid && t < 20) begin
            step(1);
            t++;
        end
        check("pending arvalid", 64'(m_arvalid), 64'h1);
        m_arready = 1'b1;
        inj_req++;
        exp_q.push_back(40'h1C00);
        step(10);
        compare_obs("coincident");
        check("coincident arvalid", 64'(m_arvalid), 64'h0);

        // Go dropped while AR is pending: handshake still completes, then drain.
        do_reset();
        cont = 1'b1;
        base_addr = 40'h1000;
        limit_addr = 40'h2000;
        exp_q.push_back(40'h1000);
        go = 1'b1;
        step(3);
        check("third-cycle arvalid", 64'(m_arvalid), 64'h1);
        go = 1'b0;
        step(3);
        check("held arvalid", 64'(m_arvalid), 64'h1);
        check("held araddr", 64'(m_araddr), 64'h1000);
        m_arready = 1'b1;
        step(1);
        m_arready = 1'b0;
        step(3);
        compare_obs("godrop");
        check("drain busy", 64'(busy), 64'h1);
        check("drain arvalid", 64'(m_arvalid), 64'h0);
        check("drain mb_count", 64'(mb_count), 64'd1);
        inj_req++;
        step(3);
        check("drained busy", 64'(busy), 64'h0);

        // Asynchronous reset mid-ISSUE, then underflow error and its clear.
        do_reset();
        cont = 1'b1;
        base_addr = 40'h1000;
        limit_addr = 40'h2000;
        go = 1'b1;
        step(3);
        check("pre-reset arvalid", 64'(m_arvalid), 64'h1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async arvalid", 64'(m_arvalid), 64'h0);
        check("async read_addr", 64'(read_addr), 64'h0);
        check("async busy", 64'(busy), 64'h0);
        go = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(2);
        check("err clean", 64'(err), 64'h0);
        inj_req++;
        step(3);
        check("err set", 64'(err), 64'h1);
        step(5);
        check("err sticky", 64'(err), 64'h1);
        go = 1'b1;
        step(2);
        check("err cleared on start", 64'(err), 64'h0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gg_dma_rdaddr.md
Name: gg_dma_rdaddr

Overview:
- AXI4 read-address generator for the macroblock read DMA. Issues one 24-beat, 128-bit burst per macroblock from a circular DRAM buffer bounded by base and limit.
- Read-data beats flow to the chroma-DC insert stage through the R channel. This block only monitors m_rlast to track outstanding bursts.
- Two read modes. Original mode stalls while the read pointer equals the write pointer. Recon mode (cont=1) ignores the write pointer and re-reads continuously.

Parameters:
- ADDR_W, 40, AXI byte address width.
- MB_STRIDE, 512, byte stride between macroblocks. Power of two, 384 or more, divides 4096, so no burst crosses a 4KB boundary.
- MAX_OUT, 4, maximum outstanding bursts (AR accepted, m_rlast not yet seen).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- go  in  1  run enable (register bit 0)
- cont  in  1  recon mode; ignore write_addr (register bit 1)
- base_addr  in  ADDR_W  buffer start, MB_STRIDE aligned
- limit_addr  in  ADDR_W  buffer end, exclusive
- write_addr  in  ADDR_W  producer write pointer
- read_addr  out  ADDR_W  current read pointer (status)
- busy  out  1  state != IDLE
- waiting  out  1  stalled on read_addr == write_addr
- mb_count  out  16  bursts issued since go rose, wraps at 65535
- m_arvalid  out  1  AXI AR valid
- m_arready  in  1  AXI AR ready
- m_araddr  out  ADDR_W  burst address
- m_arlen  out  8  constant 8'd23
- m_arsize  out  3  constant 3'b100
- m_arcache  out  4  constant 4'b0011
- m_rvalid  in  1  R monitor
- m_rready  in  1  R monitor
- m_rlast  in  1  R monitor
- err  out  1  sticky: m_rlast seen with zero outstanding

Behaviour:
- Reset (asynchronous, any state, including mid-burst) sets state IDLE.
  - read_addr, m_araddr, mb_count, outstanding count: 0.
  - m_arvalid, busy, waiting, err: 0.
- Reset while AR is pending is permitted only with the interconnect also in reset.
- States: IDLE, CHECK, ISSUE, DRAIN.
- IDLE: if go=1, then read_addr <= base_addr, mb_count <= 0, err <= 0, go to CHECK.
- CHECK, evaluated in priority order:
  - go=0 -> DRAIN.
  - cont=0 and read_addr == write_addr -> stay in CHECK, waiting=1.
  - outstanding == MAX_OUT -> stay in CHECK.
  - Otherwise m_araddr <= read_addr, go to ISSUE.
- ISSUE: m_arvalid=1 with m_araddr stable until m_arready. The handshake is completed even if go drops.
  - On handshake, outstanding increments and mb_count increments.
  - read_addr <= (read_addr + MB_STRIDE >= limit_addr) ? base_addr : read_addr + MB_STRIDE.
  - Then go to CHECK.
- DRAIN: when outstanding == 0, go to IDLE. go rising while in DRAIN is ignored until IDLE is reached.
- Outstanding count:
  - Decrements on m_rvalid & m_rready & m_rlast.
  - An AR handshake and an R-last in the same cycle leave it unchanged.
  - R-last at 0 holds it at 0 and sets err.
- Latency: go=1 in IDLE gives m_arvalid in the 3rd cycle (IDLE->CHECK->ISSUE). Minimum AR spacing is 2 cycles, well under 24 data beats per burst.
- waiting is combinational from CHECK state and the pointer compare.
- Wrap: pointer sum is ADDR_W+1 bits wide, so no overflow ambiguity. limit_addr <= base_addr is a software error: the pointer reloads base_addr every burst.

Optional Feature:
- Macro GG_DMA_RDADDR_PERF_EN.
- Defined: adds outputs stall_wr_cycles[31:0] and stall_ar_cycles[31:0], both saturating and cleared on go rising in IDLE.
  - stall_wr_cycles counts CHECK cycles with waiting=1.
  - stall_ar_cycles counts cycles in ISSUE with m_arready=0, plus CHECK cycles blocked by MAX_OUT.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package gg_dma_pkg holds:
  - state enum rdaddr_state_t (IDLE, CHECK, ISSUE, DRAIN);
  - constants MB_BEATS=24, AXI_ARLEN_MB=8'd23, AXI_ARSIZE_128=3'b100, AXI_ARCACHE_DMA=4'b0011.
- One sub-module is natural: gg_dma_outstanding, the up/down outstanding counter with full flag and underflow error.

Test Plan:
- Original mode, base=0x1000, limit=0x1800, write_addr=0x1400, arready=1, R-last returned promptly -> exactly 2 bursts at 0x1000 and 0x1200, then waiting=1. Set write_addr=0x1600 -> one burst at 0x1400, then waiting=1.
- Recon mode (cont=1), base=0x1000, limit=0x1600, 7 bursts -> addresses 0x1000, 0x1200, 0x1400, 0x1000, 0x1200, 0x1400, 0x1000; mb_count=7; arlen=23 on every burst.
- No R-last returned, MAX_OUT=4 -> exactly 4 AR handshakes, then stalled in CHECK. Single R-last -> exactly one more AR. R-last coincident with an AR handshake -> count unchanged.
- Drop go while m_arvalid=1 and arready=0 -> m_arvalid and m_araddr held until arready, then DRAIN. busy stays 1 until the last outstanding R-last, then 0.
- Pulse reset_n low mid-ISSUE -> m_arvalid=0, read_addr=0, busy=0 immediately (asynchronous). An R-last with zero outstanding after restart -> err=1, held until the next go start.
